fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, meaning the instruction word used for bubbles and flushes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port PCWrite, input, 1 bit: PC-advance enable from the hazard unit.
REQ-006 SHALL have port IF_IDWrite, input, 1 bit: IF/ID register load enable from the hazard unit.
REQ-007 SHALL have port IF_Flush, input, 1 bit: kill the instruction entering IF/ID.
REQ-008 SHALL have port PCSrc, input, 2 bits: next-PC select (00 seq, 01 branch, 10 jump, 11 jr).
REQ-009 SHALL have ports BranchAddr, JumpAddr and JrAddr, input, 32 bits each: redirect targets.
REQ-010 SHALL have ports imem_req (output, 1) and imem_addr (output, 32): the instruction memory request and its word-aligned address.
REQ-011 SHALL have ports imem_ack (input, 1) and imem_rdata (input, 32): a one-cycle response strobe and its data.
REQ-012 SHALL have ports IF_ID_Instr (output, 32), IF_ID_PC4 (output, 32) and IF_ID_Valid (output, 1): the IF/ID register contents.
REQ-013 SHALL have port fetch_busy, output, 1 bit: high while the FSM is in FETCH or DROP and imem_ack is low.

Function
REQ-014 SHALL implement a three-state FSM: FETCH (request outstanding), HOLD (fetched word buffered), DROP (stale request outstanding).
REQ-015 SHALL drive imem_req high in FETCH and DROP, and low in HOLD.
REQ-016 SHALL hold imem_addr equal to the internal fetch_addr register, and SHALL keep imem_addr stable from request until imem_ack.
REQ-017 SHALL define a redirect as PCSrc != 00; a redirect has priority over every other event in every state.
REQ-018 SHALL, on a redirect, load PC and fetch_addr with the selected target, with these transitions:
- FETCH without ack -> DROP (fetch_addr held until ack).
- FETCH with ack -> FETCH at the target.
- HOLD -> FETCH (buffer discarded).
- DROP -> DROP, or FETCH at the target if ack arrives.
REQ-019 SHALL define consume as (FETCH with imem_ack, or HOLD) and PCWrite and IF_IDWrite and no redirect.
REQ-020 SHALL, on consume, load IF/ID with {word, PC+4, Valid=1}, advance PC and fetch_addr to PC+4 (mod 2^32), and enter FETCH, where word is imem_rdata in FETCH or the buffered word in HOLD.
REQ-021 SHALL, on FETCH with imem_ack and without consume, capture imem_rdata into the buffer, enter HOLD, and leave PC unchanged.
REQ-022 SHALL, when in DROP with imem_ack, discard imem_rdata and enter FETCH at the current PC.
REQ-023 SHALL, with IF_IDWrite=1 and no consume (fetch pending or DROP), load IF/ID with a bubble {NOP_INSTR, 0, Valid=0}.
REQ-024 SHALL hold IF/ID unchanged when IF_IDWrite=0.
REQ-025 SHALL, when IF_Flush=1, load IF/ID with a bubble regardless of IF_IDWrite, with priority over REQ-020, REQ-023 and REQ-024; PC follows REQ-018.
REQ-026 SHALL ignore imem_ack while in HOLD.
REQ-027 SHALL make PC+4 wrap silently at 2^32.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force PC=fetch_addr=RESET_PC, state=FETCH, buffer=NOP_INSTR, IF_ID_Instr=NOP_INSTR, IF_ID_PC4=0 and IF_ID_Valid=0.
REQ-029 SHALL, while rst_n=0, hold imem_req=0, and SHALL assert imem_req in the first cycle after release.
REQ-030 SHALL abandon any response in flight when reset is asserted mid-request; the memory side is reset by the same rst_n.

Structure
REQ-031 SHALL place the PCSrc encodings, the FSM state encoding and the NOP_INSTR default in the shared cpu package.
REQ-032 SHALL contain exactly one sub-module, pc_next_mux: combinational selection of PC+4, BranchAddr, JumpAddr or JrAddr by PCSrc.

Verification
REQ-033 Reset release with ack every cycle -> imem_addr 0,4,8; IF/ID Valid=1 with PC4 4,8,12.
REQ-034 imem_ack delayed 3 cycles at addr 0x10, IF_IDWrite=1 -> 3 bubbles (Valid=0), then Instr=rdata, PC4=0x14.
REQ-035 Ack at 0x20 with PCWrite=IF_IDWrite=0 for 2 cycles -> HOLD, imem_req=0, IF/ID frozen; on release IF/ID gets the buffered word, PC4=0x24.
REQ-036 PCSrc=01, BranchAddr=0x100 and IF_Flush=1 while the fetch at 0x40 is pending -> DROP, stale data discarded, next imem_addr=0x100, IF/ID Valid=0.
REQ-037 PC=0xFFFF_FFFC, consume -> PC4=0x0000_0000, next imem_addr=0.
REQ-038 rst_n low mid-DROP -> immediately PC=RESET_PC, imem_req=0, Valid=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared cpu encodings for next-PC select, fetch FSM state and the default bubble word.
package fetch_stage_pkg;
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JR     = 2'b11
  } pcsrc_e;
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DROP  = 2'b10
  } fetch_state_e;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory request/response bus between the fetch stage and the memory.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: selects the next PC from sequential, branch, jump or register-jump targets.
module pc_next_mux
  import fetch_stage_pkg::*;
(
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] branch_i,
  input  logic [31:0] jump_i,
  input  logic [31:0] jr_i,
  output logic [31:0] next_pc_o
);
  assign next_pc_o = pcsrc_i == PC_BRANCH ? branch_i :
                     pcsrc_i == PC_JUMP   ? jump_i   :
                     pcsrc_i == PC_JR     ? jr_i     : pc4_i;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction fetch FSM with one-word buffer, and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         PCWrite,
  input  logic         IF_IDWrite,
  input  logic         IF_Flush,
  input  logic [1:0]   PCSrc,
  input  logic [31:0]  BranchAddr,
  input  logic [31:0]  JumpAddr,
  input  logic [31:0]  JrAddr,
  fetch_stage_if.master imem,
  output logic [31:0]  IF_ID_Instr,
  output logic [31:0]  IF_ID_PC4,
  output logic         IF_ID_Valid,
  output logic         fetch_busy
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, fa_q, fa_d, buf_q, buf_d, instr_q, instr_d, pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] next_pc, word;
  logic        redirect, have_word, consume, bubble;
  pc_next_mux u_mux (
    .pcsrc_i  (PCSrc),
    .pc4_i    (pc_q + 32'd4),
    .branch_i (BranchAddr),
    .jump_i   (JumpAddr),
    .jr_i     (JrAddr),
    .next_pc_o(next_pc)
  );
  assign redirect  = PCSrc != PC_SEQ;
  assign have_word = state_q == ST_HOLD || (state_q == ST_FETCH && imem.imem_ack);
  assign consume   = have_word && PCWrite && IF_IDWrite && !redirect;
  assign word      = state_q == ST_HOLD ? buf_q : imem.imem_rdata;
  assign bubble    = IF_Flush || (IF_IDWrite && !consume);
  assign instr_d   = bubble ? NOP_INSTR : consume ? word : instr_q;
  assign pc4_d     = bubble ? 32'd0 : consume ? pc_q + 32'd4 : pc4_q;
  assign valid_d   = bubble ? 1'b0 : consume ? 1'b1 : valid_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fa_d    = fa_q;
    buf_d   = buf_q;
    if (redirect) begin
      pc_d = next_pc;
      // an unacknowledged request must keep its address, so it is drained in DROP
      if (state_q == ST_HOLD || imem.imem_ack) begin
        state_d = ST_FETCH;
        fa_d    = next_pc;
      end else begin
        state_d = ST_DROP;
      end
    end else if (consume) begin
      pc_d    = next_pc;
      fa_d    = next_pc;
      state_d = ST_FETCH;
    end else if (state_q == ST_FETCH && imem.imem_ack) begin
      buf_d   = imem.imem_rdata;
      state_d = ST_HOLD;
    end else if (state_q == ST_DROP && imem.imem_ack) begin
      fa_d    = pc_q;
      state_d = ST_FETCH;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      fa_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fa_q    <= fa_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end
  assign imem.imem_req  = rst_n && state_q != ST_HOLD;
  assign imem.imem_addr = fa_q;
  assign IF_ID_Instr    = instr_q;
  assign IF_ID_PC4      = pc4_q;
  assign IF_ID_Valid    = valid_q;
  assign fetch_busy     = state_q != ST_HOLD && !imem.imem_ack;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a request/buffer level reference model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCWrite, IF_IDWrite, IF_Flush;
  logic [1:0]  PCSrc;
  logic [31:0] BranchAddr, JumpAddr, JrAddr;
  logic [31:0] IF_ID_Instr, IF_ID_PC4;
  logic        IF_ID_Valid, fetch_busy;
  int          checks = 0, failures = 0;
  logic [31:0] m_pc, m_addr, m_buf, m_instr, m_pc4;
  logic        m_valid, m_buffered, m_stale;
  always #5 clk = ~clk;
  fetch_stage_if imem ();
  fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PCWrite    (PCWrite),
    .IF_IDWrite (IF_IDWrite),
    .IF_Flush   (IF_Flush),
    .PCSrc      (PCSrc),
    .BranchAddr (BranchAddr),
    .JumpAddr   (JumpAddr),
    .JrAddr     (JrAddr),
    .imem       (imem),
    .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_PC4  (IF_ID_PC4),
    .IF_ID_Valid(IF_ID_Valid),
    .fetch_busy (fetch_busy)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_pc = 0; m_addr = 0; m_buf = 0; m_instr = 0; m_pc4 = 0;
    m_valid = 0; m_buffered = 0; m_stale = 0;
  endtask
  task automatic drive(input logic [1:0] src, input logic pcw, input logic ifw, input logic fl, input logic ak);
    PCSrc = src; PCWrite = pcw; IF_IDWrite = ifw; IF_Flush = fl;
    imem.imem_ack   = ak;
    imem.imem_rdata = (ak && !m_buffered) ? mem(m_addr) : $urandom;
  endtask
  // one clock: check bus outputs, clock, advance the model, check IF/ID
  task automatic cycle();
    logic redirect, word_ok, cons, ack;
    logic [31:0] tgt, word;
    #1;
    chk("imem_req", 32'(imem.imem_req), 32'(!m_buffered));
    chk("imem_addr", imem.imem_addr, m_addr);
    chk("fetch_busy", 32'(fetch_busy), 32'(!m_buffered && !imem.imem_ack));
    @(posedge clk);
    ack      = imem.imem_ack;
    redirect = PCSrc != 2'b00;
    tgt      = PCSrc == 2'b01 ? BranchAddr : PCSrc == 2'b10 ? JumpAddr : PCSrc == 2'b11 ? JrAddr : m_pc + 4;
    word_ok  = m_buffered || (!m_stale && ack);
    word     = m_buffered ? m_buf : imem.imem_rdata;
    cons     = word_ok && PCWrite && IF_IDWrite && !redirect;
    if (IF_Flush || (IF_IDWrite && !cons)) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (cons) begin
      m_instr = word; m_pc4 = m_pc + 4; m_valid = 1;
    end
    if (redirect) begin
      m_pc = tgt;
      if (m_buffered || ack) begin
        m_addr = tgt; m_buffered = 0; m_stale = 0;
      end else m_stale = 1;
    end else if (cons) begin
      m_pc = m_pc + 4; m_addr = m_pc; m_buffered = 0;
    end else if (!m_buffered && !m_stale && ack) begin
      m_buffered = 1; m_buf = imem.imem_rdata;
    end else if (m_stale && ack) begin
      m_stale = 0; m_addr = m_pc;
    end
    #1;
    chk("if_id_instr", IF_ID_Instr, m_instr);
    chk("if_id_pc4", IF_ID_PC4, m_pc4);
    chk("if_id_valid", 32'(IF_ID_Valid), 32'(m_valid));
  endtask
  initial begin
    logic [1:0] src;
    model_reset();
    BranchAddr = 0; JumpAddr = 0; JrAddr = 0;
    drive(2'b00, 1, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", 32'(imem.imem_req), 0);
    chk("reset_addr", imem.imem_addr, 0);
    chk("reset_valid", 32'(IF_ID_Valid), 0);
    chk("reset_instr", IF_ID_Instr, 0);
    chk("reset_pc4", IF_ID_PC4, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("release_req", 32'(imem.imem_req), 1);
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1, 1, 0, 1);
      chk("seq_addr", imem.imem_addr, 32'(4 * i));
      cycle();
      chk("seq_pc4", IF_ID_PC4, 32'(4 * (i + 1)));
      chk("seq_valid", 32'(IF_ID_Valid), 1);
    end
    drive(2'b00, 1, 1, 0, 1); cycle();
    chk("slow_addr", imem.imem_addr, 32'h10);
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1, 1, 0, 0); cycle();
      chk("slow_bubble", 32'(IF_ID_Valid), 0);
    end
    drive(2'b00, 1, 1, 0, 1); cycle();
    chk("slow_instr", IF_ID_Instr, mem(32'h10));
    chk("slow_pc4", IF_ID_PC4, 32'h14);
    JumpAddr = 32'h20;
    drive(2'b10, 1, 0, 0, 1); cycle();
    drive(2'b00, 0, 0, 0, 1); cycle();
    chk("hold_req", 32'(imem.imem_req), 0);
    chk("hold_frozen", IF_ID_PC4, 32'h14);
    drive(2'b00, 0, 0, 0, 1); cycle();
    chk("hold_frozen2", IF_ID_Instr, mem(32'h10));
    drive(2'b00, 1, 1, 0, 0); cycle();
    chk("hold_instr", IF_ID_Instr, mem(32'h20));
    chk("hold_pc4", IF_ID_PC4, 32'h24);
    JumpAddr = 32'h40; BranchAddr = 32'h100;
    drive(2'b10, 1, 1, 0, 1); cycle();
    drive(2'b01, 1, 1, 1, 0); cycle();
    chk("drop_addr_held", imem.imem_addr, 32'h40);
    chk("drop_req", 32'(imem.imem_req), 1);
    chk("drop_valid", 32'(IF_ID_Valid), 0);
    drive(2'b00, 1, 1, 0, 1); cycle();
    chk("drop_new_addr", imem.imem_addr, 32'h100);
    chk("drop_stale_valid", 32'(IF_ID_Valid), 0);
    drive(2'b00, 1, 1, 0, 1); cycle();
    chk("drop_target_instr", IF_ID_Instr, mem(32'h100));
    JumpAddr = 32'hFFFF_FFFC;
    drive(2'b10, 1, 1, 0, 1); cycle();
    drive(2'b00, 1, 1, 0, 1); cycle();
    chk("wrap_pc4", IF_ID_PC4, 0);
    chk("wrap_addr", imem.imem_addr, 0);
    JumpAddr = 32'h80;
    drive(2'b10, 1, 0, 0, 0); cycle();
    chk("pre_reset_valid", 32'(IF_ID_Valid), 1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_req", 32'(imem.imem_req), 0);
    chk("async_addr", imem.imem_addr, 0);
    chk("async_valid", 32'(IF_ID_Valid), 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      BranchAddr = $urandom & ~32'h3;
      JumpAddr   = $urandom & ~32'h3;
      JrAddr     = $urandom & ~32'h3;
      src = $urandom_range(0, 9) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      drive(src, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
